// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply issue controller.
// Lane geometry, operand selectors and the issue FSM state encoding.
package matmul_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;

    localparam logic OP_A = 1'b0;
    localparam logic OP_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } mm_state_t;

endpackage

// File: rtl/operand_bank.sv
// One operand: four 32-bit lanes plus a per-lane written mask.
// Ports: clk/rst, write port (wr_en, wr_idx, wr_data), clr (mask clear),
//        mask (lanes written since last clear), lanes (packed 128-bit view).
module operand_bank
    import matmul_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [1:0]              wr_idx,
    input  logic [LANE_W-1:0]       wr_data,
    input  logic                    clr,
    output logic [LANES-1:0]        mask,
    output logic [LANES*LANE_W-1:0] lanes
);

    logic [LANES-1:0][LANE_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            mask <= '0;
        end else begin
            if (clr) begin
                mask <= '0;
            end
            if (wr_en) begin
                mem[wr_idx]  <= wr_data;
                mask[wr_idx] <= 1'b1;
            end
        end
    end

    assign lanes = mem;

endmodule

// File: rtl/matmul_issue_ctrl.sv
// Packs core-written operand lanes, issues a start pulse to the multiplier,
// captures its result and guards the wait with a watchdog.
// Ports: clk/rst; core side wr_en/wr_sel/wr_idx/wr_data, go, err_clr,
//        rd_idx/rd_data, busy, res_valid, err; multiplier side matrix_a,
//        matrix_b, mm_start, mm_done, mm_result.
module matmul_issue_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [1:0]   wr_idx,
    input  logic [31:0]  wr_data,
    input  logic         go,
    input  logic         err_clr,
    input  logic [1:0]   rd_idx,
    output logic [31:0]  rd_data,
    output logic         busy,
    output logic         res_valid,
    output logic         err,
    output logic [255:0] matrix_a,
    output logic [255:0] matrix_b,
    output logic         mm_start,
    input  logic         mm_done,
    input  logic [255:0] mm_result
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    mm_state_t state;
    mm_state_t nxt;

    logic [3:0]   mask_a;
    logic [3:0]   mask_b;
    logic [127:0] lanes_a;
    logic [127:0] lanes_b;
    logic [127:0] result;
    logic [7:0]   wd;

    logic idle;
    logic accept;
    logic wr_ok;
    logic capture;
    logic timeout;
    logic err_set;
    logic unused_hi;

    assign idle    = (state == IDLE);
    assign accept  = idle & go & ~wr_en & (&mask_a) & (&mask_b);
    assign wr_ok   = idle & wr_en & ~go;
    assign capture = (state == WAIT) & mm_done;
    assign timeout = (state == WAIT) & ~mm_done & (wd == WD_LAST);

    // Rejected go in IDLE, any write while busy, or a watchdog abort.
    assign err_set = (idle & go & ~accept) | (wr_en & ~idle) | timeout;

    operand_bank u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok & (wr_sel == OP_A)),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .clr     (accept),
        .mask    (mask_a),
        .lanes   (lanes_a)
    );

    operand_bank u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok & (wr_sel == OP_B)),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .clr     (accept),
        .mask    (mask_b),
        .lanes   (lanes_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        mm_start = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nxt = ISSUE;
                end
            end
            ISSUE: begin
                mm_start = 1'b1;
                busy     = 1'b1;
                nxt      = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (mm_done || timeout) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd        <= '0;
            result    <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd <= '0;
            end else if (state == WAIT) begin
                wd <= wd + 8'd1;
            end
            if (capture) begin
                result <= mm_result[127:0];
            end
            if (accept) begin
                res_valid <= 1'b0;
            end else if (capture) begin
                res_valid <= 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign matrix_a  = {128'b0, lanes_a};
    assign matrix_b  = {128'b0, lanes_b};
    assign rd_data   = result[{rd_idx, 5'b0} +: 32];
    assign unused_hi = ^mm_result[255:128];

endmodule

// File: tb/tb_matmul_issue_ctrl.sv
// Bench for matmul_issue_ctrl: stub multiplier, behavioural model and
// per-cycle compare, plus directed literal checks.
module tb_matmul_issue_ctrl;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic         wr_sel;
    logic [1:0]   wr_idx;
    logic [31:0]  wr_data;
    logic         go;
    logic         err_clr;
    logic [1:0]   rd_idx;
    logic [31:0]  rd_data;
    logic         busy;
    logic         res_valid;
    logic         err;
    logic [255:0] matrix_a;
    logic [255:0] matrix_b;
    logic         mm_start;
    logic         mm_done;
    logic [255:0] mm_result;

    logic         stub_en;
    logic         sdone;
    logic         fdone;
    logic [255:0] sres;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_issue_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .go        (go),
        .err_clr   (err_clr),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .busy      (busy),
        .res_valid (res_valid),
        .err       (err),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .mm_result (mm_result)
    );

    // Stub multiplier: lane-wise 32-bit product, done one cycle after start.
    always @(posedge clk) begin
        sdone <= stub_en & mm_start;
        for (int i = 0; i < 4; i++) begin
            sres[32*i +: 32] <= matrix_a[32*i +: 32] * matrix_b[32*i +: 32];
        end
        sres[255:128] <= {4{32'hA5A5_5A5A}};
    end

    assign mm_done   = sdone | fdone;
    assign mm_result = sres;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model: phase k = 0 idle, 1 issuing, 2 waiting.
    logic [31:0] m_a [4];
    logic [31:0] m_b [4];
    logic [31:0] m_r [4];
    logic [3:0]  ma, mb;
    logic        m_rv, m_err, m_live = 1'b0;
    int          k, w;

    always @(posedge clk) begin
        logic e;
        if (rst) begin
            m_live = 1'b1;
            k = 0; w = 0; ma = 0; mb = 0; m_rv = 0; m_err = 0;
            for (int i = 0; i < 4; i++) begin
                m_a[i] = 0; m_b[i] = 0; m_r[i] = 0;
            end
        end else if (m_live) begin
            e = 1'b0;
            if (k == 0) begin
                if (go) begin
                    if (wr_en || ma != 4'hF || mb != 4'hF) e = 1'b1;
                    else begin
                        ma = 0; mb = 0; m_rv = 0; k = 1;
                    end
                end else if (wr_en) begin
                    if (wr_sel) begin
                        m_b[wr_idx] = wr_data; mb[wr_idx] = 1'b1;
                    end else begin
                        m_a[wr_idx] = wr_data; ma[wr_idx] = 1'b1;
                    end
                end
            end else begin
                if (wr_en) e = 1'b1;
                if (k == 1) begin
                    k = 2; w = 0;
                end else begin
                    w++;
                    if (mm_done) begin
                        for (int i = 0; i < 4; i++) m_r[i] = mm_result[32*i +: 32];
                        m_rv = 1'b1; k = 0;
                    end else if (w == TO) begin
                        e = 1'b1; k = 0;
                    end
                end
            end
            if (e) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", busy, k != 0);
            chk("mm_start", mm_start, k == 1);
            chk("res_valid", res_valid, m_rv);
            chk("err", err, m_err);
            chk("matrix_a", matrix_a, {128'b0, m_a[3], m_a[2], m_a[1], m_a[0]});
            chk("matrix_b", matrix_b, {128'b0, m_b[3], m_b[2], m_b[1], m_b[0]});
            chk("rd_data", rd_data, m_r[rd_idx]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [1:0] idx,
                      input logic [31:0] d);
        wr_en = 1; wr_sel = sel; wr_idx = idx; wr_data = d;
        cyc();
        wr_en = 0;
    endtask

    task automatic load(input logic [31:0] a0, a1, a2, a3,
                        input logic [31:0] b0, b1, b2, b3);
        wr(0, 0, a0); wr(0, 1, a1); wr(0, 2, a2); wr(0, 3, a3);
        wr(1, 0, b0); wr(1, 1, b1); wr(1, 2, b2); wr(1, 3, b3);
    endtask

    task automatic do_go();
        go = 1;
        cyc();
        go = 0;
    endtask

    task automatic clr_err();
        err_clr = 1;
        cyc();
        err_clr = 0;
    endtask

    task automatic rdchk(input string name, input logic [1:0] idx,
                         input logic [31:0] exp);
        rd_idx = idx;
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst = 1; wr_en = 0; wr_sel = 0; wr_idx = 0; wr_data = 0;
        go = 0; err_clr = 0; rd_idx = 0; stub_en = 1; fdone = 0;
        cyc(); cyc();
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mat_a", matrix_a, 0);

        // Normal issue
        load(32'd3, -32'sd2, 32'd7, 32'h10000,
             32'd5, 32'd4, -32'sd1, 32'h10000);
        do_go();
        chk("t1_start", mm_start, 1);
        chk("t1_busy", busy, 1);
        cyc();
        chk("t2_start", mm_start, 0);
        chk("t2_rv", res_valid, 0);
        cyc();
        chk("t3_rv", res_valid, 1);
        chk("t3_busy", busy, 0);
        rdchk("r0", 0, 32'h0000000F);
        rdchk("r1", 1, 32'hFFFFFFF8);
        rdchk("r2", 2, 32'hFFFFFFF9);
        rdchk("r3", 3, 32'h00000000);

        // Incomplete operands
        wr(0, 0, 2); wr(0, 1, 3); wr(0, 2, 4); wr(0, 3, 5);
        wr(1, 0, 6); wr(1, 1, 7); wr(1, 2, 8);
        do_go();
        chk("inc_start", mm_start, 0);
        chk("inc_busy", busy, 0);
        chk("inc_err", err, 1);
        clr_err();
        chk("inc_clr", err, 0);

        // Write while busy
        wr(1, 3, 9);
        do_go();
        wr(0, 1, 32'hDEAD);
        chk("wb_err", err, 1);
        chk("wb_lane1", matrix_a[63:32], 3);
        cyc();
        chk("wb_rv", res_valid, 1);
        rdchk("wb_r0", 0, 12);
        rdchk("wb_r1", 1, 21);
        rdchk("wb_r2", 2, 32);
        rdchk("wb_r3", 3, 45);

        // Re-issue without rewriting
        clr_err();
        do_go();
        chk("re_err", err, 1);
        chk("re_start", mm_start, 0);
        clr_err();

        // Timeout
        stub_en = 0;
        load(1, 1, 1, 1, 1, 1, 1, 1);
        do_go();
        cyc(); cyc(); cyc(); cyc();
        chk("to_busy4", busy, 1);
        cyc();
        chk("to_busy", busy, 0);
        chk("to_err", err, 1);
        chk("to_rv", res_valid, 0);
        rdchk("to_r1", 1, 21);
        rdchk("to_r3", 3, 45);
        stub_en = 1;

        // Reset in WAIT, then a late done
        load(2, 2, 2, 2, 3, 3, 3, 3);
        do_go();
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        fdone = 1;
        chk("rs_mat_a", matrix_a, 0);
        chk("rs_busy", busy, 0);
        chk("rs_err", err, 0);
        rdchk("rs_rd", 1, 0);
        cyc();
        fdone = 0;
        chk("rs_rv", res_valid, 0);
        chk("rs_start", mm_start, 0);
        rdchk("rs_rd2", 3, 0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_issue_ctrl.md
# matmul_issue_ctrl

Upstream control stage for `matrix_multiplier`. The RISC-V core writes the 32-bit operand lanes here one at a time. The block packs them into the 256-bit `matrix_a`/`matrix_b` buses and issues a one-cycle `start`. It then captures the single-cycle `done`/`result` response into a result register that the core can read back. A watchdog guards against a missing `done`.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles allowed in WAIT for `mm_done` before an error abort; legal range 2–255.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: operand lane write strobe.
- `wr_sel` in 1: 0 selects operand A, 1 selects operand B.
- `wr_idx` in 2: lane index 0–3.
- `wr_data` in 32: lane value, signed two's complement.
- `go` in 1: request an issue.
- `err_clr` in 1: clears `err`.
- `rd_idx` in 2: result lane select.
- `rd_data` out 32: result lane `rd_idx`, combinational from the result register.
- `busy` out 1: high in ISSUE and WAIT.
- `res_valid` out 1: the result register holds a fresh product.
- `err` out 1: sticky error flag.
- `matrix_a` out 256: packed A lanes in [127:0]; [255:128] is always 0.
- `matrix_b` out 256: packed B lanes in [127:0]; [255:128] is always 0.
- `mm_start` out 1: one-cycle issue pulse to the multiplier.
- `mm_done` in 1: multiplier completion, valid for exactly one cycle.
- `mm_result` in 256: multiplier result; only bits [127:0] are sampled.

## Operation
- Lane packing: lane i occupies bits [32*i +: 32].
- Each operand keeps a 4-bit written mask. A write to lane i sets mask bit i. Rewriting a lane overwrites the data and leaves the mask bit set.
- FSM states and transitions:
  - IDLE -> ISSUE: on `go` when both masks are 4'hF and `wr_en` is 0. Acceptance clears both masks and `res_valid`.
  - IDLE, `go` with either mask incomplete: `go` is ignored, `err` is set, and the FSM stays in IDLE.
  - ISSUE -> WAIT: unconditional, after one cycle. `mm_start` is 1 only in ISSUE.
  - WAIT -> IDLE on `mm_done`: latch `mm_result[127:0]` into the result register and set `res_valid`.
  - WAIT -> IDLE on timeout: the watchdog reaches `TIMEOUT` without `mm_done`. Set `err`; `res_valid` stays 0 and the result register keeps its old value.
- `wr_en` in ISSUE or WAIT: the write is dropped and `err` is set. Operands must stay stable while the multiplier samples them.
- `wr_en` and `go` together in IDLE: the write is dropped, `go` is ignored, and `err` is set.
- `go` while `busy`: ignored, with no error.
- `err_clr`: clears `err` at the next edge. If a new error condition occurs in the same cycle, the set wins.
- Arithmetic: the block performs none. `rd_data = result_reg[32*rd_idx +: 32]`.

## Timing
- Reset values:
  - FSM = IDLE.
  - Masks, operand registers and result register = 0.
  - `mm_start`, `busy`, `res_valid` and `err` = 0.
  - `matrix_a` and `matrix_b` = 0.
- Write latency: `wr_en` at edge t updates `matrix_a`/`matrix_b` from t+1.
- Issue sequence:
  - `go` accepted at edge t.
  - `mm_start` and `busy` are high during cycle t+1.
  - With the standard multiplier, `mm_done` arrives in cycle t+2. The capture happens at the edge ending t+2. `res_valid` = 1 and `busy` = 0 from t+3.
- Minimum go-to-`res_valid` latency is 3 cycles.
- Watchdog:
  - Cleared on entering WAIT and incremented each WAIT cycle without `mm_done`.
  - The abort edge is the one where the count equals `TIMEOUT`-1.
  - `mm_done` in that same cycle wins over the timeout.
- `mm_done` outside WAIT is ignored.
- `rst` mid-operation returns everything to reset values at the next edge. No `mm_start` is emitted afterwards.

## Structure
- Shared package `matmul_pkg`:
  - `LANES` = 4 and `LANE_W` = 32.
  - `OP_A` = 1'b0 and `OP_B` = 1'b1.
  - FSM enum `mm_state_t` {IDLE, ISSUE, WAIT}.
- Sub-module `operand_bank`: holds 4×32 storage plus the written mask, with write port, mask clear and a packed 128-bit output. It is instantiated twice, once for A and once for B. The FSM, watchdog and result register stay in the top level.

## Test plan
- Normal issue with a stub multiplier that asserts `mm_done` the cycle after `mm_start`:
  - Stimulus: A = {3, −2, 7, 0x10000}, B = {5, 4, −1, 0x10000}, then `go`.
  - Required: `mm_start` is a single pulse one cycle after `go`. `res_valid` rises 3 cycles after `go`.
  - Required: `rd_idx` 0–3 read 0x0000000F, 0xFFFFFFF8, 0xFFFFFFF9, 0x00000000.
- Incomplete operands: write only A lanes 0–3 and B lanes 0–2, then `go`. Required: no `mm_start`, `err` = 1, FSM stays IDLE. Then `err_clr` returns `err` to 0.
- Write while busy: stimulus `wr_en` with `wr_idx` = 1 during ISSUE. Required: `err` = 1, `matrix_a` unchanged, and the result matches the pre-write operands.
- Timeout: with `TIMEOUT` = 4 and a stub that never asserts `mm_done`, issue a `go`.
  - Required: `busy` drops after 4 WAIT cycles, `err` = 1, `res_valid` = 0.
  - Required: the result register still holds the previous product.
- Reset: assert `rst` in the WAIT cycle. Required: all outputs are 0 the next cycle, and a late `mm_done` is ignored.
- Re-issue: after a successful issue, `go` without rewriting operands. Required: `err` = 1, because the masks were cleared on acceptance.
